// File: rtl/wb_boot_loader.sv
// wb_boot_loader
//   Wishbone B3 classic master that streams a program image into system
//   memory and holds the CPU in reset until the image is fully written.
//
//   Ports:
//     wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//     ld_base_i                 load base address (captured on first word, [1:0] forced 0)
//     ld_valid_i/ld_ready_o     word stream handshake
//     ld_data_i, ld_last_i      word data, final-word qualifier
//     wbm_*                     Wishbone master interface (single writes, cti/bte classic)
//     cpu_rst_o                 CPU reset request, released RST_HOLD cycles after final ack
//     done_o, err_o             sticky completion / failure flags
//     word_cnt_o                words acknowledged so far
module wb_boot_loader #(
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned RST_HOLD  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] ld_base_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] word_cnt_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_BACKOFF = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
  localparam logic [8:0]  RETRY_LIMIT = 9'(MAX_RETRY);
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic [31:0] base_reg;
  logic        last_reg;
  logic [7:0]  retry_cnt;
  logic [8:0]  retry_nxt;
  logic [15:0] hold_cnt;
  logic        take;
  logic [31:0] base_eff;
  logic [31:0] word_adr;

  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  assign take      = (state == S_IDLE) && ld_valid_i && ld_ready_o;
  assign retry_nxt = {1'b0, retry_cnt} + 9'd1;
  // The first word of an image takes its base straight from the port; later
  // words reuse the captured base.
  assign base_eff  = (word_cnt_o == '0) ? (ld_base_i & WORD_MASK) : base_reg;
  assign word_adr  = base_eff + {word_cnt_o[29:0], 2'b00};

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (take) state_n = S_WRITE;
      S_WRITE: begin
        if (wbm_err_i)      state_n = S_FAIL;
        else if (wbm_ack_i) state_n = last_reg ? S_HOLD : S_IDLE;
        else if (wbm_rty_i) state_n = (retry_nxt > RETRY_LIMIT) ? S_FAIL : S_BACKOFF;
      end
      S_BACKOFF: state_n = S_WRITE;
      S_HOLD:    if (hold_cnt == HOLD_LAST) state_n = S_DONE;
      S_DONE:    state_n = S_DONE;
      S_FAIL:    state_n = S_FAIL;
      default:   state_n = S_IDLE;
    endcase
  end

  // Bus and status outputs are registered from the next state so that they
  // line up with the state they describe without any combinational path
  // from wbm_ack_i/err_i/rty_i to the outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      ld_ready_o <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      word_cnt_o <= '0;
      base_reg   <= '0;
      last_reg   <= 1'b0;
      retry_cnt  <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      ld_ready_o <= (state_n == S_IDLE);
      wbm_cyc_o  <= (state_n == S_WRITE);
      wbm_stb_o  <= (state_n == S_WRITE);
      wbm_we_o   <= (state_n == S_WRITE);
      wbm_sel_o  <= {4{state_n == S_WRITE}};
      cpu_rst_o  <= (state_n != S_DONE);
      done_o     <= (state_n == S_DONE);
      err_o      <= (state_n == S_FAIL);

      if (take) begin
        wbm_adr_o <= word_adr;
        wbm_dat_o <= ld_data_i;
        last_reg  <= ld_last_i;
        if (word_cnt_o == '0) base_reg <= ld_base_i & WORD_MASK;
      end

      // err outranks ack and rty; an errored cycle changes no counters.
      if ((state == S_WRITE) && !wbm_err_i) begin
        if (wbm_ack_i) begin
          word_cnt_o <= word_cnt_o + 32'd1;
          retry_cnt  <= '0;
        end else if (wbm_rty_i) begin
          retry_cnt  <= retry_nxt[7:0];
        end
      end

      hold_cnt <= (state == S_HOLD) ? hold_cnt + 16'd1 : '0;
    end
  end

endmodule

// File: tb/tb_wb_boot_loader.sv
// tb_wb_boot_loader
//   Table of load words with expected addresses and counts, a scoreboard
//   queue of expected bus writes consumed by a reactive Wishbone slave, and
//   hand-written sequences for retry exhaustion, err/ack collision and
//   reset in the middle of a write.
module tb_wb_boot_loader;

  logic        wb_clk_i   = 1'b0;
  logic        wb_rst_i   = 1'b1;
  logic [31:0] ld_base_i  = '0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_data_i  = '0;
  logic        ld_last_i  = 1'b0;
  logic        ld_ready_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i  = 1'b0;
  logic        wbm_err_i  = 1'b0;
  logic        wbm_rty_i  = 1'b0;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] word_cnt_o;

  wb_boot_loader #(.MAX_RETRY(8), .RST_HOLD(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .ld_base_i  (ld_base_i),
    .ld_valid_i (ld_valid_i),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_cti_o  (wbm_cti_o),
    .wbm_bte_o  (wbm_bte_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .wbm_rty_i  (wbm_rty_i),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  typedef struct {
    bit          rst;
    logic [31:0] base;
    logic [31:0] data;
    bit          last;
    int          waits;
    int          rtys;
    logic [31:0] exp_adr;
    logic [31:0] exp_cnt;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tv[9];

  int n_cmp = 0;
  int n_bad = 0;

  // Slave behaviour for the word currently on the bus.
  int wait_left    = 0;
  int rty_left     = 0;
  bit err_on       = 1'b0;
  bit ack_with_err = 1'b0;
  bit expect_idle  = 1'b0;
  int rty_seen     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every strobed cycle must present the scoreboard head word; the cycle after
  // a retry must be bus-idle.
  task automatic slave();
    forever begin
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      if (expect_idle) begin
        check("backoff_cyc", 32'(wbm_cyc_o), 32'd0);
        expect_idle = 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cycle", 32'(exp_q.size()), 32'd1);
        end else begin
          check("wb_adr", wbm_adr_o, exp_q[0].adr);
          check("wb_dat", wbm_dat_o, exp_q[0].dat);
          check("wb_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'h0000_001f);
          check("ready_in_cycle", 32'(ld_ready_o), 32'd0);
        end
        if (wait_left > 0) begin
          wait_left--;
        end else if (rty_left > 0) begin
          wbm_rty_i = 1'b1;
          rty_left--;
          rty_seen++;
          expect_idle = 1'b1;
        end else if (err_on) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = ack_with_err;
        end else begin
          wbm_ack_i = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i     = 1'b0;
    exp_q.delete();
    wait_left    = 0;
    rty_left     = 0;
    err_on       = 1'b0;
    ack_with_err = 1'b0;
    expect_idle  = 1'b0;
    rty_seen     = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int t;
    t = 0;
    @(negedge wb_clk_i);
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    ld_last_i  = last;
    while (!ld_ready_o && t < 200) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (!ld_ready_o) check("ready_timeout", 32'(ld_ready_o), 32'd1);
    @(posedge wb_clk_i);
    #1;
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  // Returns #1 after the negedge on which the slave acknowledged the head word.
  task automatic wait_drain();
    int t;
    t = 0;
    do begin
      @(negedge wb_clk_i);
      #1;
      t++;
    end while (exp_q.size() != 0 && t < 200);
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_err();
    int t;
    t = 0;
    while (!err_o && t < 200) begin
      @(negedge wb_clk_i);
      #1;
      t++;
    end
  endtask

  // Called in the ack cycle of the final word: cpu_rst_o must stay high for
  // exactly RST_HOLD cycles after it, then drop together with done_o rising.
  task automatic check_hold(input logic [31:0] exp_cnt);
    int hi;
    hi = 0;
    do begin
      @(negedge wb_clk_i);
      #1;
      if (cpu_rst_o) begin
        hi++;
        if (hi == 1) check("ready_in_hold", 32'(ld_ready_o), 32'd0);
      end
    end while (cpu_rst_o && hi < 100);
    check("hold_cycles", 32'(hi), 32'd16);
    check("done", 32'(done_o), 32'd1);
    check("done_err", 32'(err_o), 32'd0);
    check("done_cnt", word_cnt_o, exp_cnt);
    check("done_ready", 32'(ld_ready_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    fork
      slave();
    join_none

    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("rst_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_ready", 32'(ld_ready_o), 32'd0);
    check("rst_flags", {29'd0, cpu_rst_o, done_o, err_o}, 32'd4);
    check("rst_cnt", word_cnt_o, 32'd0);
    check("rst_cti_bte", {27'd0, wbm_cti_o, wbm_bte_o}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    //         rst   base          data          last  wt rty exp_adr       exp_cnt
    tv[0] = '{1'b1, 32'h0000_0100, 32'h1111_1111, 1'b0, 0, 0, 32'h0000_0100, 32'd1};
    tv[1] = '{1'b0, 32'hDEAD_0000, 32'h2222_2222, 1'b0, 0, 0, 32'h0000_0104, 32'd2};
    tv[2] = '{1'b0, 32'hDEAD_0000, 32'h3333_3333, 1'b1, 0, 0, 32'h0000_0108, 32'd3};
    tv[3] = '{1'b1, 32'h0000_0200, 32'hAAAA_0001, 1'b0, 0, 0, 32'h0000_0200, 32'd1};
    tv[4] = '{1'b0, 32'h0000_0000, 32'hAAAA_0002, 1'b0, 5, 0, 32'h0000_0204, 32'd2};
    tv[5] = '{1'b0, 32'h0000_0000, 32'hAAAA_0003, 1'b1, 0, 0, 32'h0000_0208, 32'd3};
    tv[6] = '{1'b1, 32'h0000_0300, 32'hBBBB_0001, 1'b0, 0, 2, 32'h0000_0300, 32'd1};
    tv[7] = '{1'b0, 32'h0000_0000, 32'hBBBB_0002, 1'b1, 0, 0, 32'h0000_0304, 32'd2};
    tv[8] = '{1'b1, 32'hFFFF_FFFE, 32'hCCCC_0001, 1'b1, 0, 0, 32'hFFFF_FFFC, 32'd1};

    for (int unsigned i = 0; i < 9; i++) begin
      if (tv[i].rst) do_reset();
      ld_base_i = tv[i].base;
      wait_left = tv[i].waits;
      rty_left  = tv[i].rtys;
      rty_seen  = 0;
      exp_q.push_back('{adr: tv[i].exp_adr, dat: tv[i].data});
      send(tv[i].data, tv[i].last);
      wait_drain();
      check("rty_seen", 32'(rty_seen), 32'(tv[i].rtys));
      if (tv[i].last) begin
        check_hold(tv[i].exp_cnt);
      end else begin
        @(negedge wb_clk_i);
        #1;
        check("cnt_after_ack", word_cnt_o, tv[i].exp_cnt);
        check("ready_after_ack", 32'(ld_ready_o), 32'd1);
        check("cpu_rst_loading", 32'(cpu_rst_o), 32'd1);
      end
    end

    // Nine consecutive retries with MAX_RETRY=8.
    do_reset();
    ld_base_i = 32'h0000_0400;
    rty_left  = 9;
    exp_q.push_back('{adr: 32'h0000_0400, dat: 32'h4444_0001});
    send(32'h4444_0001, 1'b1);
    wait_err();
    check("rty_fail_count", 32'(rty_seen), 32'd9);
    check("rty_fail_flags", {29'd0, cpu_rst_o, done_o, err_o}, 32'd5);
    check("rty_fail_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rty_fail_cnt", word_cnt_o, 32'd0);
    repeat (3) @(negedge wb_clk_i);
    check("fail_sticky", {30'd0, err_o, ld_ready_o}, 32'd2);

    // ack and err in the same cycle: err wins.
    do_reset();
    ld_base_i    = 32'h0000_0600;
    err_on       = 1'b1;
    ack_with_err = 1'b1;
    exp_q.push_back('{adr: 32'h0000_0600, dat: 32'h6666_0001});
    send(32'h6666_0001, 1'b0);
    wait_err();
    check("ackerr_flags", {29'd0, cpu_rst_o, done_o, err_o}, 32'd5);
    check("ackerr_cnt", word_cnt_o, 32'd0);

    // Reset during a stalled write of word 2, then a fresh one-word load.
    do_reset();
    ld_base_i = 32'h0000_0500;
    exp_q.push_back('{adr: 32'h0000_0500, dat: 32'h5555_0001});
    send(32'h5555_0001, 1'b0);
    wait_drain();
    wait_left = 20;
    exp_q.push_back('{adr: 32'h0000_0504, dat: 32'h5555_0002});
    send(32'h5555_0002, 1'b0);
    @(negedge wb_clk_i);
    check("midrst_in_write", 32'(wbm_cyc_o), 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    check("midrst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("midrst_cnt", word_cnt_o, 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    exp_q.delete();
    wait_left = 0;
    ld_base_i = 32'hFFFF_FFFC;
    exp_q.push_back('{adr: 32'hFFFF_FFFC, dat: 32'h7777_0001});
    send(32'h7777_0001, 1'b1);
    wait_drain();
    check_hold(32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_boot_loader.md
Name: wb_boot_loader

Overview:
- Wishbone B3 master that loads a program image into system memory before the CPU runs. It sits upstream of orpsoc_multi_top and is the front-door alternative to backdoor ELF preloading.
- Accepts 32-bit words on a valid/ready stream and writes them to consecutive word addresses from a base address.
- Holds the CPU in reset until the final word is acknowledged, then releases it after a programmable hold time.

Parameters:
- MAX_RETRY, 8: consecutive rty responses tolerated per word before failing; range 1..255.
- RST_HOLD, 16: cycles between final ack and cpu_rst_o deassertion; range 1..65535.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- ld_base_i  in  32  load base address; sampled on first word handshake, bits [1:0] ignored (forced 0)
- ld_valid_i  in  1  word available
- ld_data_i  in  32  word data (big-endian, as stored in memory)
- ld_last_i  in  1  qualifies final word of image
- ld_ready_o  out  1  loader accepts word this cycle
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects, always 4'hf during a cycle
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  constant 3'b000 (classic)
- wbm_bte_o  out  2  constant 2'b00
- wbm_ack_i  in  1  ack
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry
- cpu_rst_o  out  1  CPU reset request, high until load completes
- done_o  out  1  load complete, sticky
- err_o  out  1  load failed, sticky
- word_cnt_o  out  32  words acknowledged so far

Behaviour:
- Reset values: all wbm_* outputs 0; ld_ready_o 0; cpu_rst_o 1; done_o 0; err_o 0; word_cnt_o 0; retry count 0; hold count 0; state IDLE.
- Reset takes effect on the clock edge only. Reset mid-transfer drops cyc/stb on that edge, discards the word, and reasserts cpu_rst_o.
- State IDLE:
  - ld_ready_o=1; no other output changes.
  - On ld_valid_i & ld_ready_o: capture data and last flag.
  - Address = (word_cnt_o==0 ? {ld_base_i[31:2],2'b00} : base_reg) + 4*word_cnt_o, modulo 2^32 (wraps silently).
  - Go to WRITE.
- State WRITE:
  - cyc=stb=we=1, sel=4'hf, ld_ready_o=0.
  - Response priority: err > ack > rty.
  - err: go to FAIL.
  - ack: word_cnt_o+1. If last flag set, go to HOLD; otherwise go to IDLE. cyc/stb low next cycle.
  - rty: retry count+1. If the new count > MAX_RETRY, go to FAIL; otherwise go to BACKOFF.
  - No response: remain in WRITE, outputs stable (no timeout).
  - Retry count clears on ack.
- State BACKOFF: one cycle with cyc=stb=0, then return to WRITE with the same address and data.
- State HOLD:
  - Hold counter runs from 0 to RST_HOLD-1; cpu_rst_o stays 1 and ld_ready_o=0.
  - At terminal count, go to DONE.
- State DONE:
  - cpu_rst_o=0, done_o=1, ld_ready_o=0.
  - ld_valid_i is ignored; stays here until reset.
- State FAIL:
  - err_o=1, cpu_rst_o=1, ld_ready_o=0, bus idle.
  - Stays here until reset.
- Timing:
  - Handshake in cycle N puts stb high in cycle N+1.
  - With a zero-wait slave (ack in N+1), ld_ready_o is high again in N+2.
  - Peak throughput is 1 word per 2 cycles.
- done_o and err_o are never both 1.
- word_cnt_o wraps at 2^32 without a flag.

Test Plan:
- Base 0x0000_0100, words 0x11111111/0x22222222/0x33333333 (last on 3rd), zero-wait slave.
  - Required: writes to 0x100/0x104/0x108 with sel=4'hf.
  - word_cnt_o=3.
  - cpu_rst_o falls exactly 16 cycles after the 3rd ack; done_o=1.
- Slave inserts 5 wait states on word 2.
  - Required: adr/dat/stb held stable throughout.
  - No extra word accepted; ld_ready_o stays 0 until after ack.
- Slave returns rty twice then ack on word 1.
  - Required: two BACKOFF cycles with cyc=0, same address re-driven, single count increment.
- rty 9 consecutive times with MAX_RETRY=8.
  - Required: FAIL; err_o=1, cpu_rst_o=1, done_o=0, cyc=0.
- ack and err asserted in the same cycle on word 1.
  - Required: err wins; err_o=1, word_cnt_o unchanged.
- wb_rst_i pulsed during WRITE of word 2, then a fresh 1-word load at base 0xFFFF_FFFC.
  - Required: cyc drops on the reset edge and word_cnt_o=0.
  - New write goes to 0xFFFF_FFFC; done_o asserts.
  - Base 0xFFFF_FFFE load: writes 0xFFFF_FFFC (low bits forced 0).
